// File: rtl/bus_ram_responder.sv
// Bus-mapped RAM slave: reads when MID matches DEV_ID, writes when SID matches, and flags range or ID conflicts.
// Latency: read data and data_oe are registered and valid 1 clock after the request is sampled; writes commit on that same edge.
// Backpressure: none. A request is accepted every cycle. Errors are counted per cycle, and the memory and bus are left untouched.
//
// Ports:
//   clk, reset (async active-low)          clock and reset
//   address_bus[15:0], data_in[DW-1:0]     bus address and write data
//   MID/MID_EN, SID/SID_EN                 master (read) and slave (write) ID qualifiers
//   data_out[DW-1:0], data_oe              registered read data and bus drive enable
//   addr_err, err_count[7:0]               sticky error flag and saturating per-cycle error count
module bus_ram_responder #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          MEMORY_DEPTH = 256,
    parameter logic [4:0]  DEV_ID       = 5'h4,
    parameter logic [15:0] BASE_ADDR    = 16'h8000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           address_bus,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [4:0]            MID,
    input  logic                  MID_EN,
    input  logic [4:0]            SID,
    input  logic                  SID_EN,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_oe,
    output logic                  addr_err,
    output logic [7:0]            err_count
);

    localparam int          IDX_W    = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    // The range end is computed one bit wider so that a window ending at 16'hFFFF still compares correctly.
    localparam logic [16:0] END_ADDR = {1'b0, BASE_ADDR} + 17'(MEMORY_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    logic             rd_req;
    logic             wr_req;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             oe_nxt;
    logic             rd_load;
    logic             mem_we;
    logic             err_entry;
    logic             err_inc;

    assign rd_req   = MID_EN && (MID == DEV_ID);
    assign wr_req   = SID_EN && (SID == DEV_ID);
    assign in_range = ({1'b0, address_bus} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, address_bus} <  END_ADDR);
    assign idx      = IDX_W'(address_bus - BASE_ADDR);

    always_comb begin
        state_nxt = IDLE;
        if (rd_req && wr_req) begin
            state_nxt = ERR;
        end else if ((rd_req || wr_req) && !in_range) begin
            state_nxt = ERR;
        end else if (rd_req) begin
            state_nxt = READ;
        end else if (wr_req) begin
            state_nxt = WRITE;
        end
    end

    // The actions below are keyed to the state being entered, so that the read data lands on the same edge that moves the FSM into READ.
    always_comb begin
        oe_nxt    = (state_nxt == READ);
        rd_load   = (state_nxt == READ);
        // A write is blocked while reset is held. A write that would be pending when reset asserts is therefore dropped.
        mem_we    = (state_nxt == WRITE) && reset;
        err_inc   = (state_nxt == ERR);
        err_entry = (state_nxt == ERR) && (state != ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            data_oe   <= 1'b0;
            data_out  <= '0;
            addr_err  <= 1'b0;
            err_count <= 8'h00;
        end else begin
            state   <= state_nxt;
            data_oe <= oe_nxt;
            if (rd_load) begin
                data_out <= mem[idx];
            end
            if (err_entry) begin
                addr_err <= 1'b1;
            end
            if (err_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'h01;
            end
        end
    end

    // The RAM has no reset on purpose. Its contents survive a reset and can be preloaded from outside.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= data_in;
        end
    end

endmodule

// File: tb/tb_bus_ram_responder.sv
module tb_bus_ram_responder;

    logic        clk;
    logic        reset;
    logic [15:0] address_bus;
    logic [7:0]  data_in;
    logic [4:0]  MID;
    logic        MID_EN;
    logic [4:0]  SID;
    logic        SID_EN;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        addr_err;
    logic [7:0]  err_count;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [7:0] ref_mem [256];
    logic       m_oe;
    logic [7:0] m_dout;
    logic       m_err;
    int         m_cnt;

    bus_ram_responder dut (
        .clk         (clk),
        .reset       (reset),
        .address_bus (address_bus),
        .data_in     (data_in),
        .MID         (MID),
        .MID_EN      (MID_EN),
        .SID         (SID),
        .SID_EN      (SID_EN),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .addr_err    (addr_err),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_oe"},   32'(data_oe),   32'(m_oe));
        chk({tag, "_dout"}, 32'(data_out),  32'(m_dout));
        chk({tag, "_err"},  32'(addr_err),  32'(m_err));
        chk({tag, "_cnt"},  32'(err_count), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_oe   = 1'b0;
        m_dout = 8'h00;
        m_err  = 1'b0;
        m_cnt  = 0;
    endtask

    // One bus cycle. The inputs are driven at the negedge, and the outputs are compared at the next negedge, after the DUT has clocked.
    task automatic step(input logic [4:0] mid, input logic mid_en, input logic [4:0] sid,
                        input logic sid_en, input logic [15:0] addr, input logic [7:0] din,
                        input string tag);
        bit rd;
        bit wr;
        bit inr;
        int off;
        MID         = mid;
        MID_EN      = mid_en;
        SID         = sid;
        SID_EN      = sid_en;
        address_bus = addr;
        data_in     = din;
        rd  = mid_en && (mid == 5'd4);
        wr  = sid_en && (sid == 5'd4);
        off = int'(addr) - 32'h8000;
        inr = (off >= 0) && (off < 256);
        if ((rd && wr) || ((rd || wr) && !inr)) begin
            m_oe  = 1'b0;
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end else if (rd) begin
            m_oe   = 1'b1;
            m_dout = ref_mem[off];
        end else begin
            m_oe = 1'b0;
            if (wr) ref_mem[off] = din;
        end
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        step(5'd0, 1'b0, 5'd0, 1'b0, 16'h0000, 8'h00, tag);
    endtask

    // Asserts reset at the current negedge, holds it over one rising edge, and releases it with the bus idle.
    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_rst_oe"},   32'(data_oe),   32'd0);
        chk({tag, "_rst_dout"}, 32'(data_out),  32'd0);
        chk({tag, "_rst_err"},  32'(addr_err),  32'd0);
        chk({tag, "_rst_cnt"},  32'(err_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        MID_EN = 1'b0;
        SID_EN = 1'b0;
        reset  = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0]  saved;
        logic [15:0] a;
        logic [4:0]  mid;
        logic [4:0]  sid;
        int          r;

        reset       = 1'b0;
        address_bus = 16'h0000;
        data_in     = 8'h00;
        MID         = 5'd0;
        MID_EN      = 1'b0;
        SID         = 5'd0;
        SID_EN      = 1'b0;
        model_reset();
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = 8'($urandom);
            dut.mem[i]  = ref_mem[i];
        end

        repeat (2) @(negedge clk);
        chk("reset_oe",   32'(data_oe),   32'd0);
        chk("reset_dout", 32'(data_out),  32'd0);
        chk("reset_err",  32'(addr_err),  32'd0);
        chk("reset_cnt",  32'(err_count), 32'd0);
        reset = 1'b1;

        // A read at the first mapped address returns its data one clock later.
        dut.mem[0] = 8'h3C;
        ref_mem[0] = 8'h3C;
        step(5'd4, 1'b1, 5'd0, 1'b0, 16'h8000, 8'h00, "rd8000");
        chk("rd8000_oe_const",   32'(data_oe),  32'd1);
        chk("rd8000_dout_const", 32'(data_out), 32'h3C);

        // A one-clock write, followed by a read back of the same address.
        step(5'd0, 1'b0, 5'd4, 1'b1, 16'h8002, 8'h25, "wr8002");
        chk("wr8002_oe_const", 32'(data_oe), 32'd0);
        step(5'd4, 1'b1, 5'd0, 1'b0, 16'h8002, 8'h00, "rb8002");
        chk("rb8002_dout_const", 32'(data_out), 32'h25);

        // An out-of-range read raises an error.
        idle("idle0");
        step(5'd4, 1'b1, 5'd0, 1'b0, 16'h0000, 8'h00, "rd0000");
        chk("rd0000_oe_const",  32'(data_oe),   32'd0);
        chk("rd0000_err_const", 32'(addr_err),  32'd1);
        chk("rd0000_cnt_const", 32'(err_count), 32'd1);
        idle("idle1");

        // An ID conflict lasting 3 cycles does not write and does not drive the bus.
        reset_pulse("pre_conf");
        saved = ref_mem[1];
        for (int i = 0; i < 3; i++) begin
            step(5'd4, 1'b1, 5'd4, 1'b1, 16'h8001, ~saved, "conflict");
        end
        chk("conf_cnt_const", 32'(err_count), 32'd3);
        chk("conf_oe_const",  32'(data_oe),   32'd0);
        step(5'd4, 1'b1, 5'd0, 1'b0, 16'h8001, 8'h00, "conf_rb");
        chk("conf_mem1_const", 32'(data_out), 32'(saved));

        // Edges of the mapped window.
        step(5'd4, 1'b1, 5'd0, 1'b0, 16'h80FF, 8'h00, "rd80ff");
        step(5'd4, 1'b1, 5'd0, 1'b0, 16'h8100, 8'h00, "rd8100");
        step(5'd0, 1'b0, 5'd4, 1'b1, 16'h7FFF, 8'h11, "wr7fff");
        step(5'd0, 1'b0, 5'd4, 1'b1, 16'h80FF, 8'hA5, "wr80ff");
        step(5'd4, 1'b1, 5'd0, 1'b0, 16'h80FF, 8'h00, "rb80ff");

        // Randomized traffic, including address changes in consecutive reads.
        for (int i = 0; i < 400; i++) begin
            mid = ($urandom_range(0, 3) != 0) ? 5'd4 : 5'($urandom_range(0, 31));
            sid = ($urandom_range(0, 3) != 0) ? 5'd4 : 5'($urandom_range(0, 31));
            r   = int'($urandom_range(0, 9));
            if (r < 7)       a = 16'h8000 + 16'($urandom_range(0, 255));
            else if (r == 7) a = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8100;
            else             a = 16'($urandom);
            step(mid, 1'($urandom_range(0, 1)), sid, 1'($urandom_range(0, 2) == 0),
                 a, 8'($urandom), "rand");
        end

        // The error counter saturates and does not wrap.
        reset_pulse("pre_sat");
        for (int i = 0; i < 300; i++) begin
            step(5'd4, 1'b1, 5'd0, 1'b0, 16'h0100, 8'h00, "sat");
        end
        chk("sat_cnt_const", 32'(err_count), 32'hFF);
        idle("sat_exit");
        chk("sat_hold_const", 32'(err_count), 32'hFF);
        chk("sat_err_const",  32'(addr_err),  32'd1);

        // Reset asserted during a pending write: the write is dropped.
        saved = ref_mem[16];
        MID_EN      = 1'b0;
        SID         = 5'd4;
        SID_EN      = 1'b1;
        address_bus = 16'h8010;
        data_in     = ~saved;
        reset_pulse("mid_wr");
        step(5'd4, 1'b1, 5'd0, 1'b0, 16'h8010, 8'h00, "mid_wr_rb");
        chk("mid_wr_mem_const", 32'(data_out), 32'(saved));

        // Reset asserted during a read drops data_oe at once and preserves the memory.
        step(5'd4, 1'b1, 5'd0, 1'b0, 16'h8005, 8'h00, "pre_rst_rd");
        reset_pulse("mid_rd");
        step(5'd4, 1'b1, 5'd0, 1'b0, 16'h8005, 8'h00, "post_rst_rd");
        step(5'd4, 1'b1, 5'd0, 1'b0, 16'h8002, 8'h00, "post_rst_rd2");
        idle("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
